// File: rtl/ysyx_22041071_fetch_stage_if.sv
// Fetch-stage bus bundle: redirect inputs, instruction-memory request/response
// and the decode-facing head port.
//
// Handshake: a transfer happens on a rising clk edge where both valid and ready
// are high (imem_req_valid/imem_req_ready, valid2/ready2). Once raised, valid
// and its payload may still be withdrawn by a redirect in the same cycle;
// ready never depends on valid. imem_resp_valid has no ready: the fetch stage
// always accepts a response word.
interface ysyx_22041071_fetch_stage_if #(
  parameter int ADDR_W = 64
);
  // redirects
  logic              redirect_id;
  logic [ADDR_W-1:0] redirect_id_pc;
  logic              redirect_ex;
  logic [ADDR_W-1:0] redirect_ex_pc;
  // instruction memory
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_resp_valid;
  logic [31:0]       imem_resp_data;
  // decode head
  logic [ADDR_W-1:0] PC2;
  logic [31:0]       Ins1;
  logic              valid2;
  logic              ready2;

  // fetch-stage side
  modport master (
    input  redirect_id, redirect_id_pc, redirect_ex, redirect_ex_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, ready2,
    output imem_req_valid, imem_req_addr, PC2, Ins1, valid2
  );

  // environment side (memory + decode)
  modport slave (
    output redirect_id, redirect_id_pc, redirect_ex, redirect_ex_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, ready2,
    input  imem_req_valid, imem_req_addr, PC2, Ins1, valid2
  );
endinterface

// File: rtl/ysyx_22041071_fetch_stage.sv
// Instruction-fetch stage. Owns the fetch PC, issues in-order requests to
// instruction memory, buffers returned words in a small FIFO and presents the
// head {PC2, Ins1} to decode. Redirects from decode (jal) and execute
// (branch/jalr) restart fetch and discard responses still in flight.
//
// Optional feature: define YSYX_22041071_IF_PERF_EN to add the
// perf_fetch_cnt / perf_drop_cnt event counters.
module ysyx_22041071_fetch_stage #(
  parameter int                ADDR_W     = 64,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(64'h80000000),
  parameter int                FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  ysyx_22041071_fetch_stage_if.master bus,
  output logic [1:0]                  state_dbg
`ifdef YSYX_22041071_IF_PERF_EN
  ,
  output logic [31:0]                 perf_fetch_cnt,
  output logic [31:0]                 perf_drop_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [31:0] NOP_INS = 32'h00000013;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop_cnt;

  logic [ADDR_W-1:0] pc_mem  [FIFO_DEPTH];
  logic [31:0]       ins_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  fifo_count;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic              fifo_empty;
  logic              fifo_full;
  logic              head_fire;
  logic              ex_taken;
  logic              id_taken;
  logic              redirect_taken;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W:0]    credit_used;
  logic              credit_ok;
  logic              req_valid;
  logic              req_fire;
  logic              resp_valid;
  logic              resp_drop;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  out_after_resp;
  logic [CNT_W-1:0]  drop_cnt_nxt;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));

  // Execute redirect always wins; a decode redirect only counts when its jal
  // is actually being handed to decode this cycle.
  assign ex_taken       = bus.redirect_ex;
  assign head_fire      = bus.valid2 & bus.ready2;
  assign id_taken       = bus.redirect_id & head_fire;
  assign redirect_taken = ex_taken | id_taken;
  assign redirect_pc    = ex_taken ? bus.redirect_ex_pc : bus.redirect_id_pc;

  // Credit: every in-flight request owns a FIFO slot, so a response can
  // always be pushed without backpressure on the memory.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok   = (credit_used < (CNT_W + 1)'(FIFO_DEPTH));

  assign req_valid = (state == S_FETCH) & ~redirect_taken & credit_ok;
  assign req_fire  = req_valid & bus.imem_req_ready;

  // A response is stale if it belongs to a pre-redirect stream (drop_cnt) or
  // arrives in the very cycle a redirect happens.
  assign resp_valid = bus.imem_resp_valid;
  assign resp_drop  = resp_valid & ((drop_cnt != '0) | redirect_taken);
  assign push       = resp_valid & ~resp_drop;
  assign pop        = head_fire;

  // Requests still in flight once this cycle's response is consumed; on a
  // redirect these are exactly the responses that must be thrown away.
  assign out_after_resp = outstanding - CNT_W'(resp_valid);

  // Next drop counter, shared by the state machine and the counter register.
  always_comb begin
    drop_cnt_nxt = drop_cnt;
    if (redirect_taken) begin
      drop_cnt_nxt = out_after_resp;
    end else if (resp_valid && (drop_cnt != '0)) begin
      drop_cnt_nxt = drop_cnt - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.valid2         = ~fifo_empty & ~bus.redirect_ex;
  assign bus.PC2            = fifo_empty ? fetch_pc : pc_mem[rd_ptr];
  assign bus.Ins1           = fifo_empty ? NOP_INS  : ins_mem[rd_ptr];
  assign state_dbg          = state;

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Control FSM: one idle cycle after reset, then fetch; flush while stale
  // responses are still owed by the memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: state <= (redirect_taken && (drop_cnt_nxt != '0)) ? S_FLUSH : S_FETCH;
        S_FLUSH: state <= (drop_cnt_nxt == '0) ? S_FETCH : S_FLUSH;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Fetch PC and the PC of the next response to be buffered; both jump
  // together on a redirect so the new stream lines up with its responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else if (redirect_taken) begin
      fetch_pc <= redirect_pc;
      resp_pc  <= redirect_pc;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(4);
      if (push)     resp_pc  <= resp_pc + ADDR_W'(4);
    end
  end

  // In-flight request count and stale-response count.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(resp_valid);
      drop_cnt    <= drop_cnt_nxt;
    end
  end

  // FIFO pointers/occupancy; any redirect empties the buffer (on a decode
  // redirect the head has just been popped, the rest is wrong-path).
  always_ff @(posedge clk) begin
    if (reset || redirect_taken) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage; contents are only meaningful below fifo_count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= resp_pc;
      ins_mem[wr_ptr] <= bus.imem_resp_data;
    end
  end

`ifdef YSYX_22041071_IF_PERF_EN
  logic [31:0] flushed_entries;

  // Buffered entries thrown away by a redirect (decode keeps its head).
  always_comb begin
    flushed_entries = '0;
    if (ex_taken) begin
      flushed_entries = 32'(fifo_count);
    end else if (id_taken) begin
      flushed_entries = 32'(fifo_count) - 32'd1;
    end
  end

  // Event counters: instructions delivered and work discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(pop);
      perf_drop_cnt  <= perf_drop_cnt + 32'(resp_drop) + flushed_entries;
    end
  end
`endif

  // The credit rule must keep the buffer from ever being pushed while full.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

endmodule

// File: tb/tb_ysyx_22041071_fetch_stage.sv
// Directed bench for ysyx_22041071_fetch_stage: a fixed-latency in-order
// instruction memory (word = ~addr[31:0]) and a decode stub driving ready2.
module tb_ysyx_22041071_fetch_stage;

  localparam int ADDR_W = 64;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ysyx_22041071_fetch_stage_if #(.ADDR_W(ADDR_W)) bus ();
  logic [1:0] state_dbg;
`ifdef YSYX_22041071_IF_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  ysyx_22041071_fetch_stage #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
`ifdef YSYX_22041071_IF_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  // ---------------- memory model / scoreboard state ----------------
  logic [ADDR_W-1:0] addr_q[$];
  int                due_q[$];
  logic [ADDR_W-1:0] exp_q[$];
  int cyc     = 0;
  int mem_lat = 1;
  int n_vec   = 0;
  int n_err   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive this cycle's memory response, then let combinational outputs settle.
  task automatic settle();
    if (addr_q.size() > 0 && due_q[0] <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = ~addr_q[0][31:0];
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
    end
    #1;
  endtask

  // Advance one clock and update the memory model with what was accepted.
  task automatic clk_edge();
    bit                was_rst = reset;
    bit                fire    = bus.imem_req_valid & bus.imem_req_ready;
    bit                rvalid  = bus.imem_resp_valid;
    logic [ADDR_W-1:0] addr    = bus.imem_req_addr;
    @(posedge clk);
    #1;
    if (was_rst) begin
      addr_q.delete();
      due_q.delete();
    end else begin
      if (rvalid) begin
        void'(addr_q.pop_front());
        void'(due_q.pop_front());
      end
      if (fire) begin
        addr_q.push_back(addr);
        due_q.push_back(cyc + mem_lat);
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      settle();
      clk_edge();
    end
  endtask

  task automatic clear_inputs();
    bus.redirect_id    = 1'b0;
    bus.redirect_id_pc = '0;
    bus.redirect_ex    = 1'b0;
    bus.redirect_ex_pc = '0;
    bus.imem_req_ready = 1'b1;
    bus.ready2         = 1'b0;
  endtask

  // Two reset edges; returns at the start of the first post-reset cycle.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    run(2);
    reset = 1'b0;
  endtask

  // Wait (bounded) for the next head handshake and compare it.
  task automatic expect_pop(input string tag, input logic [ADDR_W-1:0] exp_pc);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      settle();
      if (bus.valid2 && bus.ready2) begin
        check({tag, "_pc"}, bus.PC2, exp_pc);
        check({tag, "_ins"}, {32'h0, bus.Ins1}, {32'h0, ~exp_pc[31:0]});
        seen = 1'b1;
      end
      clk_edge();
    end
    if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int nreq;
    clear_inputs();
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;

    // reset state
    reset = 1'b1;
    run(2);
    settle();
    check("rst_valid2", {63'h0, bus.valid2}, 64'd0);
    check("rst_req_valid", {63'h0, bus.imem_req_valid}, 64'd0);
    check("rst_pc2", bus.PC2, 64'h80000000);
    check("rst_ins1", {32'h0, bus.Ins1}, 64'h13);
    check("rst_state", {62'h0, state_dbg}, {62'h0, S_IDLE});

    // 1: in-order stream, 1-cycle memory, decode always ready
    do_reset();
    mem_lat = 1;
    bus.ready2 = 1'b1;
    exp_q.push_back(64'h80000000);
    exp_q.push_back(64'h80000004);
    exp_q.push_back(64'h80000008);
    while (exp_q.size() > 0) expect_pop("t1", exp_q.pop_front());

    // 2: decode stalled -> only FIFO_DEPTH requests, head held
    do_reset();
    mem_lat = 1;
    bus.ready2 = 1'b0;
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      settle();
      if (bus.imem_req_valid && bus.imem_req_ready) nreq++;
      clk_edge();
    end
    check("t2_nreq", 64'(nreq), 64'd2);
    settle();
    check("t2_valid2", {63'h0, bus.valid2}, 64'd1);
    check("t2_pc2", bus.PC2, 64'h80000000);
    check("t2_ins1", {32'h0, bus.Ins1}, 64'h7fffffff);
    check("t2_req_valid", {63'h0, bus.imem_req_valid}, 64'd0);
    // decode redirect without a head handshake is ignored
    bus.redirect_id = 1'b1;
    bus.redirect_id_pc = 64'h80000400;
    settle();
    clk_edge();
    bus.redirect_id = 1'b0;
    settle();
    check("t2_id_ignored_pc2", bus.PC2, 64'h80000000);
    check("t2_id_ignored_state", {62'h0, state_dbg}, {62'h0, S_FETCH});

    // 3: execute redirect with two requests in flight
    do_reset();
    mem_lat = 3;
    bus.ready2 = 1'b1;
    run(3);
    bus.redirect_ex = 1'b1;
    bus.redirect_ex_pc = 64'h80001000;
    settle();
    check("t3_redir_req_valid", {63'h0, bus.imem_req_valid}, 64'd0);
    clk_edge();
    bus.redirect_ex = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("t3_flush_state", {62'h0, state_dbg}, {62'h0, S_FLUSH});
      check("t3_flush_req", {63'h0, bus.imem_req_valid}, 64'd0);
      check("t3_flush_valid2", {63'h0, bus.valid2}, 64'd0);
      clk_edge();
    end
    settle();
    check("t3_refetch_state", {62'h0, state_dbg}, {62'h0, S_FETCH});
    check("t3_refetch_req", {63'h0, bus.imem_req_valid}, 64'd1);
    check("t3_refetch_addr", bus.imem_req_addr, 64'h80001000);
    clk_edge();
    expect_pop("t3", 64'h80001000);

    // 4: decode jal redirect with two entries buffered
    do_reset();
    mem_lat = 1;
    bus.ready2 = 1'b0;
    run(4);
    bus.ready2 = 1'b1;
    bus.redirect_id = 1'b1;
    bus.redirect_id_pc = 64'h80000100;
    settle();
    check("t4_head_valid2", {63'h0, bus.valid2}, 64'd1);
    check("t4_head_pc2", bus.PC2, 64'h80000000);
    clk_edge();
    bus.redirect_id = 1'b0;
    settle();
    check("t4_after_valid2", {63'h0, bus.valid2}, 64'd0);
    check("t4_after_addr", bus.imem_req_addr, 64'h80000100);
    check("t4_after_req", {63'h0, bus.imem_req_valid}, 64'd1);
    clk_edge();
    expect_pop("t4", 64'h80000100);

    // 5: execute and decode redirect together -> execute wins, no pop
    do_reset();
    mem_lat = 1;
    bus.ready2 = 1'b0;
    run(4);
    bus.ready2 = 1'b1;
    bus.redirect_ex = 1'b1;
    bus.redirect_ex_pc = 64'h80002000;
    bus.redirect_id = 1'b1;
    bus.redirect_id_pc = 64'h80000200;
    settle();
    check("t5_valid2", {63'h0, bus.valid2}, 64'd0);
    clk_edge();
    bus.redirect_ex = 1'b0;
    bus.redirect_id = 1'b0;
    settle();
    check("t5_addr", bus.imem_req_addr, 64'h80002000);
    clk_edge();
    expect_pop("t5", 64'h80002000);

    // 6: reset while flushing
    do_reset();
    mem_lat = 3;
    bus.ready2 = 1'b1;
    run(3);
    bus.redirect_ex = 1'b1;
    bus.redirect_ex_pc = 64'h80003000;
    run(1);
    bus.redirect_ex = 1'b0;
    settle();
    check("t6_in_flush", {62'h0, state_dbg}, {62'h0, S_FLUSH});
    reset = 1'b1;
    settle();
    clk_edge();
    reset = 1'b0;
    settle();
    check("t6_valid2", {63'h0, bus.valid2}, 64'd0);
    check("t6_req_valid", {63'h0, bus.imem_req_valid}, 64'd0);
    clk_edge();
    settle();
    check("t6_restart_addr", bus.imem_req_addr, 64'h80000000);
    check("t6_restart_req", {63'h0, bus.imem_req_valid}, 64'd1);
    clk_edge();
    expect_pop("t6", 64'h80000000);

    // 7: address wraps at the top of the address space
    do_reset();
    mem_lat = 1;
    bus.ready2 = 1'b1;
    run(1);
    bus.redirect_ex = 1'b1;
    bus.redirect_ex_pc = 64'hfffffffffffffffc;
    run(1);
    bus.redirect_ex = 1'b0;
    expect_pop("t7_top", 64'hfffffffffffffffc);
    expect_pop("t7_wrap", 64'h0000000000000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
